// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer for an accumulator CPU.
// It walks FETCH -> READ -> LOAD_IR -> DECODE and then, for two-byte
// instructions, through OP_READ -> OP_LATCH -> EXEC -> WB.
//
// Configuration macro:
//   CONTROL_UNIT_BRANCH_EN  when defined, opcode 8 (JMP) and 9 (JZ) are
//                           branches; otherwise they decode as illegal.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   instr             instruction-register contents (opcode in the top nibble)
//   alu_zero          ALU zero flag, consumed by JZ in OP_LATCH
//   mar_load/mar_src  MAR load strobe and source (0 = PC, 1 = RAM data_out)
//   ram_rd_en         RAM read (data valid next cycle)
//   ram_write_en      RAM write at the MAR address
//   pc_inc/pc_load    PC increment / load from RAM data_out
//   ir_load           IR load from RAM data_out
//   acc_load/acc_src  accumulator write and source (0 = ALU, 1 = RAM)
//   alu_op            000 ADD, 001 SUB, 010 AND, 011 OR (000 when unused)
//   halted            high while in HALT
//   illegal           one-cycle pulse on an undefined opcode in DECODE
//   state_dbg         current state encoding (0 = FETCH)
module control_unit #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr,
  input  logic              alu_zero,
  output logic              mar_load,
  output logic              mar_src,
  output logic              ram_rd_en,
  output logic              ram_write_en,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              ir_load,
  output logic              acc_load,
  output logic              acc_src,
  output logic [2:0]        alu_op,
  output logic              halted,
  output logic              illegal,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StRead    = 4'd1,
    StLoadIr  = 4'd2,
    StDecode  = 4'd3,
    StOpRead  = 4'd4,
    StOpLatch = 4'd5,
    StExec    = 4'd6,
    StWb      = 4'd7,
    StHalt    = 4'd8
  } state_e;

`ifdef CONTROL_UNIT_BRANCH_EN
  localparam logic BranchEn = 1'b1;
`else
  localparam logic BranchEn = 1'b0;
`endif

  state_e state_q;

  logic [3:0] opcode;
  logic       op_nop, op_lda, op_sta, op_alu, op_jmp, op_jz, op_hlt;
  logic       op_two_byte, op_undef;
  logic [3:0] alu_sel;
  logic       unused_instr_lsbs;

  assign opcode            = instr[DATA_W-1 -: 4];
  assign unused_instr_lsbs = ^instr[DATA_W-5:0];

  assign op_nop      = (opcode == 4'h0);
  assign op_lda      = (opcode == 4'h1);
  assign op_sta      = (opcode == 4'h2);
  assign op_alu      = (opcode >= 4'h3) && (opcode <= 4'h6);
  assign op_jmp      = BranchEn && (opcode == 4'h8);
  assign op_jz       = BranchEn && (opcode == 4'h9);
  assign op_hlt      = (opcode == 4'hF);
  assign op_two_byte = op_lda || op_sta || op_alu || op_jmp || op_jz;
  assign op_undef    = !(op_nop || op_hlt || op_two_byte);
  // ADD..OR are opcodes 3..6, so the ALU select is simply opcode - 3.
  assign alu_sel     = opcode - 4'd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      unique case (state_q)
        StFetch:  state_q <= StRead;
        StRead:   state_q <= StLoadIr;
        StLoadIr: state_q <= StDecode;
        StDecode: begin
          if (op_hlt)           state_q <= StHalt;
          else if (op_two_byte) state_q <= StOpRead;
          else                  state_q <= StFetch;
        end
        StOpRead:  state_q <= StOpLatch;
        StOpLatch: state_q <= (op_jmp || op_jz) ? StFetch : StExec;
        StExec:    state_q <= op_sta ? StFetch : StWb;
        StWb:      state_q <= StFetch;
        StHalt:    state_q <= StHalt;
        default:   state_q <= StFetch;
      endcase
    end
  end

  // Outputs decode from state and instr; a reset cycle forces everything idle
  // even if the register still holds a mid-instruction state.
  always_comb begin
    mar_load     = 1'b0;
    mar_src      = 1'b0;
    ram_rd_en    = 1'b0;
    ram_write_en = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    acc_load     = 1'b0;
    acc_src      = 1'b0;
    alu_op       = 3'b000;
    halted       = 1'b0;
    illegal      = 1'b0;
    state_dbg    = 4'd0;
    if (!rst) begin
      state_dbg = state_q;
      case (state_q)
        StFetch:  mar_load = 1'b1;
        StRead: begin
          ram_rd_en = 1'b1;
          pc_inc    = 1'b1;
        end
        StLoadIr: ir_load = 1'b1;
        StDecode: begin
          mar_load = op_two_byte;
          illegal  = op_undef;
        end
        StOpRead: begin
          ram_rd_en = 1'b1;
          pc_inc    = 1'b1;
        end
        StOpLatch: begin
          if (op_jmp) begin
            pc_load = 1'b1;
          end else if (op_jz) begin
            pc_load = alu_zero;
          end else begin
            mar_load = 1'b1;
            mar_src  = 1'b1;
          end
        end
        StExec: begin
          ram_write_en = op_sta;
          ram_rd_en    = !op_sta;
        end
        StWb: begin
          acc_load = 1'b1;
          acc_src  = op_lda;
          if (op_alu) alu_op = alu_sel[2:0];
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       alu_zero;
  logic       mar_load, mar_src, ram_rd_en, ram_write_en, pc_inc, pc_load;
  logic       ir_load, acc_load, acc_src, halted, illegal;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int az_mode = 0;  // 0 random, 1 force 0, 2 force 1

`ifdef CONTROL_UNIT_BRANCH_EN
  localparam bit BranchEn = 1'b1;
`else
  localparam bit BranchEn = 1'b0;
`endif

  // Expected-output bit masks.
  localparam logic [13:0] MMar    = 14'h0001;
  localparam logic [13:0] MSrc    = 14'h0002;
  localparam logic [13:0] MRd     = 14'h0004;
  localparam logic [13:0] MWr     = 14'h0008;
  localparam logic [13:0] MInc    = 14'h0010;
  localparam logic [13:0] MPcl    = 14'h0020;
  localparam logic [13:0] MIr     = 14'h0040;
  localparam logic [13:0] MAcc    = 14'h0080;
  localparam logic [13:0] MAccSrc = 14'h0100;
  localparam logic [13:0] MIll    = 14'h1000;
  localparam logic [13:0] MHalt   = 14'h2000;

  control_unit #(.DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .alu_zero     (alu_zero),
    .mar_load     (mar_load),
    .mar_src      (mar_src),
    .ram_rd_en    (ram_rd_en),
    .ram_write_en (ram_write_en),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .ir_load      (ir_load),
    .acc_load     (acc_load),
    .acc_src      (acc_src),
    .alu_op       (alu_op),
    .halted       (halted),
    .illegal      (illegal),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] out_vec();
    return {halted, illegal, alu_op, acc_src, acc_load, ir_load, pc_load, pc_inc,
            ram_write_en, ram_rd_en, mar_src, mar_load};
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic set_az();
    case (az_mode)
      1:       alu_zero = 1'b0;
      2:       alu_zero = 1'b1;
      default: alu_zero = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Entered at posedge+1 of a cycle; checks it at negedge, leaves at next posedge+1.
  task automatic cyc(input logic [13:0] exp, input string tag, input bit is_fetch);
    @(negedge clk);
    check_eq(tag, int'(out_vec()), int'(exp));
    if (is_fetch) check_eq({tag, " state"}, int'(state_dbg), 0);
    @(posedge clk);
    #1;
    set_az();
  endtask

  // Expected per-cycle behaviour of one instruction, from the instruction-level rules.
  task automatic run_instr(input logic [7:0] ins);
    logic [3:0]  op;
    logic [13:0] wb;
    bit          two, undef;
    op    = ins[7:4];
    two   = (op >= 4'h1 && op <= 4'h6) || (BranchEn && (op == 4'h8 || op == 4'h9));
    undef = !(op == 4'h0 || op == 4'hF || two);
    cyc(MMar, $sformatf("fetch %h", ins), 1'b1);
    cyc(MRd | MInc, $sformatf("read %h", ins), 1'b0);
    cyc(MIr, $sformatf("load_ir %h", ins), 1'b0);
    instr = ins;
    if (op == 4'hF) begin
      cyc(14'h0, "decode hlt", 1'b0);
      return;
    end
    if (!two) begin
      cyc(undef ? MIll : 14'h0, $sformatf("decode %h", ins), 1'b0);
      return;
    end
    cyc(MMar, $sformatf("decode %h", ins), 1'b0);
    cyc(MRd | MInc, $sformatf("op_read %h", ins), 1'b0);
    if (op == 4'h8) begin
      cyc(MPcl, "jmp latch", 1'b0);
      return;
    end
    if (op == 4'h9) begin
      cyc(alu_zero ? MPcl : 14'h0, $sformatf("jz latch az=%0d", alu_zero), 1'b0);
      return;
    end
    cyc(MMar | MSrc, $sformatf("op_latch %h", ins), 1'b0);
    if (op == 4'h2) begin
      cyc(MWr, "sta exec", 1'b0);
      return;
    end
    cyc(MRd, $sformatf("exec %h", ins), 1'b0);
    wb = (op == 4'h1) ? (MAcc | MAccSrc) : (MAcc | 14'((op - 4'h3) << 9));
    cyc(wb, $sformatf("wb %h", ins), 1'b0);
  endtask

  // Holds rst for n cycles starting at posedge+1, checking the idle outputs.
  task automatic do_reset(input int n, input string tag);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq({tag, " outs"}, int'(out_vec()), 0);
      check_eq({tag, " state"}, int'(state_dbg), 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    set_az();
  endtask

  initial begin
    rst      = 1'b1;
    instr    = 8'h00;
    alu_zero = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2, "reset");

    // Directed programs; operand bytes only matter to the datapath.
    run_instr(8'h10);                       // LDA
    run_instr(8'h30);                       // ADD
    run_instr(8'h60);                       // OR
    run_instr(8'h4C);                       // SUB with junk LSBs
    run_instr(8'h55);                       // AND
    az_mode = 1; set_az();
    run_instr(8'h90);                       // JZ not taken (or illegal)
    az_mode = 2; set_az();
    run_instr(8'h90);                       // JZ taken (or illegal)
    run_instr(8'h83);                       // JMP (or illegal)
    az_mode = 0; set_az();
    run_instr(8'hB0);                       // illegal, then FETCH with illegal low
    run_instr(8'h7F);
    run_instr(8'h00);

    // STA interrupted by a 2-cycle reset in EXEC: no write may appear.
    cyc(MMar, "sta_rst fetch", 1'b1);
    cyc(MRd | MInc, "sta_rst read", 1'b0);
    cyc(MIr, "sta_rst load_ir", 1'b0);
    instr = 8'h20;
    cyc(MMar, "sta_rst decode", 1'b0);
    cyc(MRd | MInc, "sta_rst op_read", 1'b0);
    cyc(MMar | MSrc, "sta_rst op_latch", 1'b0);
    do_reset(2, "sta_rst");
    cyc(MMar, "after sta_rst fetch", 1'b1);
    cyc(MRd | MInc, "after sta_rst read", 1'b0);
    cyc(MIr, "after sta_rst load_ir", 1'b0);
    instr = 8'h00;
    cyc(14'h0, "after sta_rst nop", 1'b0);

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ins;
      ins = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      run_instr(ins);
    end

    // Halt is sticky until reset.
    run_instr(8'hF7);
    for (int i = 0; i < 100; i++) cyc(MHalt, "halt", 1'b0);
    do_reset(1, "halt_rst");
    run_instr(8'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning RAM word and instruction width; the opcode is instr[DATA_W-1:DATA_W-4].
REQ-002 SHALL have ports as follows.
- clk  in  1  system clock, all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- instr  in  DATA_W  current instruction-register contents.
- alu_zero  in  1  ALU zero flag.
- mar_load  out  1  MAR load strobe.
- mar_src  out  1  MAR source: 0 = PC, 1 = RAM data_out.
- ram_rd_en  out  1  RAM read enable; data is valid in the next cycle.
- ram_write_en  out  1  RAM write enable, using the MAR address.
- pc_inc  out  1  PC increment strobe.
- pc_load  out  1  PC load from RAM data_out.
- ir_load  out  1  instruction-register load from RAM data_out.
- acc_load  out  1  accumulator write strobe.
- acc_src  out  1  accumulator source: 0 = ALU result, 1 = RAM data_out.
- alu_op  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
- state_dbg  out  4  current state encoding.

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, READ, LOAD_IR, DECODE, OP_READ, OP_LATCH, EXEC, WB and HALT; all outputs SHALL be decoded from state and instr only.
REQ-004 FETCH SHALL assert mar_load with mar_src=0, then go to READ.
REQ-005 READ SHALL assert ram_rd_en and pc_inc, then go to LOAD_IR.
REQ-006 LOAD_IR SHALL assert ir_load, then go to DECODE.
REQ-007 Opcode map: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 8 JMP, 9 JZ, F HLT; A-E and 7 are undefined.
REQ-008 In DECODE, NOP and undefined opcodes SHALL go to FETCH; undefined opcodes SHALL also pulse illegal.
REQ-009 In DECODE, HLT SHALL go to HALT.
REQ-010 In DECODE, two-byte opcodes (1-6, 8, 9) SHALL assert mar_load with mar_src=0 and go to OP_READ.
REQ-011 OP_READ SHALL assert ram_rd_en and pc_inc, then go to OP_LATCH.
REQ-012 OP_LATCH, for JMP, SHALL assert pc_load and go to FETCH.
REQ-013 OP_LATCH, for JZ, SHALL assert pc_load only if alu_zero=1 (sampled in that cycle), then go to FETCH.
REQ-014 OP_LATCH, for all other two-byte opcodes, SHALL assert mar_load with mar_src=1 and go to EXEC.
REQ-015 EXEC, for STA, SHALL assert ram_write_en and go to FETCH.
REQ-016 EXEC, for LDA and ALU opcodes, SHALL assert ram_rd_en and go to WB.
REQ-017 WB SHALL assert acc_load; LDA SHALL use acc_src=1; ADD/SUB/AND/OR SHALL use acc_src=0 with alu_op equal to opcode-3.
REQ-018 Cycle counts: NOP/undefined 4, HLT 4 to reach HALT, JMP/JZ 6, STA 7, LDA/ALU 8.
REQ-019 HALT SHALL be sticky: all strobes 0 and halted=1 until rst.
REQ-020 Strobes SHALL be mutually consistent: never ram_rd_en with ram_write_en, never pc_inc with pc_load; alu_op SHALL be 000 when unused.
REQ-021 Unused instr LSBs SHALL be ignored.

Reset
REQ-022 While rst=1 at a clock edge, the state SHALL become FETCH regardless of the current state, including mid-instruction and HALT.
REQ-023 During the rst cycle all strobes, halted and illegal SHALL be 0 and state_dbg SHALL be 0 (FETCH); the first cycle after rst deasserts SHALL be FETCH.

Configuration
REQ-024 With macro CONTROL_UNIT_BRANCH_EN defined, JMP and JZ SHALL behave per REQ-012/REQ-013.
REQ-025 Without CONTROL_UNIT_BRANCH_EN, opcodes 8 and 9 SHALL be decoded as undefined per REQ-008 (single-byte, illegal pulse, no pc_load ever).

Verification
REQ-026 rst held 2 cycles mid-EXEC of STA -> ram_write_en never asserted; the next cycle after release is FETCH with mar_load=1 and mar_src=0.
REQ-027 Program 0x10,0x20 (LDA 0x20), RAM[0x20]=0x5A -> acc_load with acc_src=1 in cycle 8; pc_inc pulsed exactly twice.
REQ-028 Program 0x30,0x21 (ADD) -> alu_op=000 and acc_src=0 in WB; then 0x60,0x21 (OR) -> alu_op=011.
REQ-029 JZ 0x90,0x40 with alu_zero=0 -> no pc_load, 6 cycles; with alu_zero=1 -> pc_load in OP_LATCH; without the macro -> illegal pulse, 4 cycles.
REQ-030 Opcode 0xB0 -> illegal high for exactly 1 cycle in DECODE, then FETCH; opcode 0xF0 -> halted=1 held 100 cycles with no strobes, cleared by rst.
